layer5_result_mem_ctrl: RTL

Sequencer for the layer-5 result one-side memory: a 5×5 scratch array of layer-6 input vectors. It accepts one full feature map from the layer-5 producer in raster order and drives the write port. It then sweeps the read port `num_passes` times in raster order for the layer-6 engine, one pass per layer-6 weight set. Data words bypass this block; it generates only handshakes, addresses and strobes.

---
 rtl/layer5_ctrl_pkg.sv | 14 +
 rtl/layer5_result_mem_ctrl_raster_addr_counter.sv | 54 +++++
 rtl/layer5_result_mem_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/layer5_ctrl_pkg.sv
// Shared types and constants for the layer-5 result memory sequencer.
package layer5_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } l5_ctrl_state_t;

  localparam int L5_MAP_DIM = 5;
  localparam int L5_POS_W   = 3;

endpackage

// File: rtl/layer5_result_mem_ctrl_raster_addr_counter.sv
// Raster-order row/col position counter; wraps to (0,0) after the last position.
module raster_addr_counter
  import layer5_ctrl_pkg::*;
#(
  parameter int MAP_DIM = L5_MAP_DIM,
  parameter int POS_W   = L5_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             last
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(MAP_DIM - 1);

  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] col_q, col_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/layer5_result_mem_ctrl.sv
// Layer-5 result memory sequencer: one raster fill, then num_passes raster drains.
// Optional stall counter built when LAYER5_CTRL_STALL_CNT_EN is defined.
module layer5_result_mem_ctrl
  import layer5_ctrl_pkg::*;
#(
  parameter int MAP_DIM = L5_MAP_DIM,
  parameter int ADDR_W  = 16,
  parameter int PASS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              save_enable,
  output logic [ADDR_W-1:0] save_row_addr,
  output logic [ADDR_W-1:0] save_col_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              layer5_result_read_signal,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic [PASS_W-1:0] pass_idx,
  output logic              last_pos,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cycles
);

  localparam int POS_W = L5_POS_W;

  l5_ctrl_state_t    state_q, state_d;
  logic [PASS_W-1:0] last_pass_q, last_pass_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  logic             start_acc;
  logic             rd_hs;
  logic [POS_W-1:0] wr_row, wr_col, rd_row, rd_col;
  logic             wr_last, rd_last;

  assign start_acc = (state_q == IDLE) && start;
  assign rd_hs     = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    last_pass_d = last_pass_q;
    pass_d      = pass_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // A request for zero passes still performs one.
          last_pass_d = (num_passes == '0) ? '0 : num_passes - 1'b1;
          pass_d      = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_last) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_last) begin
          if (pass_q == last_pass_q) state_d = DONE;
          else                       pass_d  = pass_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_pass_q <= '0;
      pass_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_pass_q <= last_pass_d;
      pass_q      <= pass_d;
    end
  end

  assign save_enable = in_valid && in_ready;

  // Both counters wrap to (0,0) after the last position, which also covers the
  // clear on FILL->DRAIN and at each pass boundary.
  raster_addr_counter #(.MAP_DIM(MAP_DIM), .POS_W(POS_W)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (save_enable),
    .row     (wr_row),
    .col     (wr_col),
    .last    (wr_last)
  );

  raster_addr_counter #(.MAP_DIM(MAP_DIM), .POS_W(POS_W)) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .advance (rd_hs),
    .row     (rd_row),
    .col     (rd_col),
    .last    (rd_last)
  );

  assign save_row_addr             = {{(ADDR_W-POS_W){1'b0}}, wr_row};
  assign save_col_addr             = {{(ADDR_W-POS_W){1'b0}}, wr_col};
  assign read_row_addr             = {{(ADDR_W-POS_W){1'b0}}, rd_row};
  assign read_col_addr             = {{(ADDR_W-POS_W){1'b0}}, rd_col};
  assign layer5_result_read_signal = out_valid;
  assign pass_idx                  = pass_q;
  assign last_pos                  = rd_last;
  assign busy                      = (state_q != IDLE);

`ifdef LAYER5_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
